// File: rtl/frame_buffer_pkg.sv
// Shared types and constants for the ping-pong frame buffer arbiter.
package frame_buffer_pkg;

  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 8;

  // Read-session / bank-swap controller states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SESSION   = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } fb_state_t;

  // Requester identities used by the round-robin arbiter
  typedef enum logic {
    READER = 1'b0,
    WRITER = 1'b1
  } requester_t;

endpackage

// File: rtl/frame_buffer_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter. On a conflict the requester that lost
// the previous conflict wins; without a conflict the sole requester wins.
module rr_arbiter2
  import frame_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rd_req,
  input  logic wr_req,
  output logic rd_gnt,
  output logic wr_gnt
);

  requester_t last_conflict_reg;
  logic       conflict;

  assign conflict = rd_req & wr_req;
  assign rd_gnt   = rd_req & (~wr_req | (last_conflict_reg == WRITER));
  assign wr_gnt   = wr_req & (~rd_req | (last_conflict_reg == READER));

  // Remember who won the most recent conflict; reset favours the reader first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_conflict_reg <= WRITER;
    end else if (conflict) begin
      last_conflict_reg <= rd_gnt ? READER : WRITER;
    end
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Ping-pong frame RAM arbiter: the writer fills one bank while the SPI
// reader drains the other. Banks swap only at frame boundaries and never
// inside a read session.
module frame_buffer_arbiter
  import frame_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  wr_frame_done,
  output logic                  wr_ready,
  input  logic                  rd_session_start,
  input  logic                  rd_session_end,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_frame_valid,
  output logic [ADDR_WIDTH:0]   ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  fb_state_t             state_reg, state_next;
  logic                  rd_bank_reg;
  logic                  frame_valid_reg;
  logic                  rd_valid_reg;
  logic [ADDR_WIDTH:0]   addr_hold_reg;
  logic                  swap;
  logic                  wr_req_q;

  // A writer request is only considered while no swap is pending
  assign wr_ready = (state_reg != ST_SWAP_WAIT);
  assign wr_req_q = wr_req & wr_ready;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (resetn),
    .rd_req (rd_req),
    .wr_req (wr_req_q),
    .rd_gnt (rd_gnt),
    .wr_gnt (wr_gnt)
  );

  // RAM mux: grants use the bank in effect this cycle (pre-swap)
  always_comb begin
    ram_addr = addr_hold_reg;
    if (rd_gnt) begin
      ram_addr = {rd_bank_reg, rd_addr};
    end else if (wr_gnt) begin
      ram_addr = {~rd_bank_reg, wr_addr};
    end
  end

  assign ram_we         = wr_gnt;
  assign ram_wdata      = wr_data;
  assign rd_data        = ram_rdata;
  assign rd_valid       = rd_valid_reg;
  assign rd_frame_valid = frame_valid_reg;

  // Session FSM: decides when a completed frame may be swapped to the reader.
  // A session end is handled before a coincident session start.
  always_comb begin
    state_next = state_reg;
    swap       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (wr_frame_done)    swap       = 1'b1;
        if (rd_session_start) state_next = ST_SESSION;
      end
      ST_SESSION: begin
        if (rd_session_end) begin
          // Frame finishing as the session closes needs no deferral
          if (wr_frame_done) swap = 1'b1;
          state_next = rd_session_start ? ST_SESSION : ST_IDLE;
        end else if (wr_frame_done) begin
          state_next = ST_SWAP_WAIT;
        end
      end
      ST_SWAP_WAIT: begin
        if (rd_session_end) begin
          swap       = 1'b1;
          state_next = rd_session_start ? ST_SESSION : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, bank and frame-valid registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      rd_bank_reg     <= 1'b0;
      frame_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (swap) begin
        rd_bank_reg     <= ~rd_bank_reg;
        frame_valid_reg <= 1'b1;
      end
    end
  end

  // Read-valid pipeline and held RAM address for idle cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid_reg  <= 1'b0;
      addr_hold_reg <= '0;
    end else begin
      rd_valid_reg <= rd_gnt;
      if (rd_gnt | wr_gnt) addr_hold_reg <= ram_addr;
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Testbench for frame_buffer_arbiter: directed vector table, reset corner
// case, then randomized traffic against a behavioural model.
module tb_frame_buffer_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_req, wr_gnt, wr_frame_done, wr_ready;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data, ram_wdata, ram_rdata;
  logic          rd_session_start, rd_session_end, rd_req, rd_gnt;
  logic          rd_valid, rd_frame_valid, ram_we;
  logic [AW:0]   ram_addr;

  always #5 clk = ~clk;

  frame_buffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .wr_frame_done(wr_frame_done), .wr_ready(wr_ready),
    .rd_session_start(rd_session_start), .rd_session_end(rd_session_end),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_frame_valid(rd_frame_valid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Single-port RAM primitive with 1-cycle read latency
  logic [DW-1:0] ram_mem [0:(1<<(AW+1))-1];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  // Abstract view: which bank the reader sees, whether a session is open,
  // whether a finished frame is waiting, and whose turn it is on a clash.
  bit          m_bank, m_sess, m_pend, m_fv, m_reader_turn, m_rv;
  logic [AW:0] m_hold;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [0:(1<<(AW+1))-1];
  bit          e_rg, e_wg, e_wrdy;
  logic [AW:0] e_addr;

  task automatic model_reset();
    m_bank = 0; m_sess = 0; m_pend = 0; m_fv = 0;
    m_reader_turn = 1; m_rv = 0; m_hold = '0;
  endtask

  task automatic model_comb();
    bit wv;
    e_wrdy = !m_pend;
    wv = wr_req && e_wrdy;
    if (rd_req && wv) begin
      e_rg = m_reader_turn; e_wg = !m_reader_turn;
    end else begin
      e_rg = rd_req; e_wg = wv;
    end
    if (e_rg)      e_addr = {m_bank, rd_addr};
    else if (e_wg) e_addr = {~m_bank, wr_addr};
    else           e_addr = m_hold;
  endtask

  task automatic model_edge();
    bit do_swap;
    if (rd_req && wr_req && e_wrdy) m_reader_turn = !e_rg;
    if (e_rg || e_wg) m_hold = e_addr;
    if (e_rg) m_rdata = m_mem[e_addr];
    if (e_wg) m_mem[e_addr] = wr_data;
    m_rv = e_rg;
    do_swap = 0;
    if (!m_sess) begin
      if (wr_frame_done) do_swap = 1;
      if (rd_session_start) m_sess = 1;
    end else if (rd_session_end) begin
      if (m_pend || wr_frame_done) do_swap = 1;
      m_pend = 0;
      m_sess = rd_session_start;
    end else if (wr_frame_done) begin
      m_pend = 1;
    end
    if (do_swap) begin m_bank = !m_bank; m_fv = 1; end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rr; logic [AW-1:0] ra; logic wr; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic done; logic st; logic en;
    logic e_rg; logic e_wg; logic [AW:0] e_addr; logic e_wrdy; logic e_rv; logic e_fv;
    logic chk_d; logic [DW-1:0] e_d;
  } vec_t;

  vec_t vecs [20];

  task automatic drive_idle();
    rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    wr_frame_done = 0; rd_session_start = 0; rd_session_end = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << (AW + 1)); i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end
    //            rr ra    wr wa    wd     dn st en   rg wg addr      wrdy rv fv  cd d
    vecs[0]  = '{1, 14'd5, 0, 14'd0, 8'h00, 0, 0, 0,  1, 0, 15'h0005, 1, 0, 0,  0, 8'h00};
    vecs[1]  = '{0, 14'd0, 1, 14'd3, 8'hA5, 0, 0, 0,  0, 1, 15'h4003, 1, 1, 0,  0, 8'h00};
    vecs[2]  = '{0, 14'd0, 0, 14'd0, 8'h00, 1, 0, 0,  0, 0, 15'h4003, 1, 0, 0,  0, 8'h00};
    vecs[3]  = '{1, 14'd3, 0, 14'd0, 8'h00, 0, 0, 0,  1, 0, 15'h4003, 1, 0, 1,  0, 8'h00};
    vecs[4]  = '{0, 14'd0, 0, 14'd0, 8'h00, 0, 0, 0,  0, 0, 15'h4003, 1, 1, 1,  1, 8'hA5};
    vecs[5]  = '{0, 14'd0, 0, 14'd0, 8'h00, 0, 1, 0,  0, 0, 15'h4003, 1, 0, 1,  0, 8'h00};
    vecs[6]  = '{0, 14'd0, 0, 14'd0, 8'h00, 1, 0, 0,  0, 0, 15'h4003, 1, 0, 1,  0, 8'h00};
    vecs[7]  = '{0, 14'd0, 1, 14'd7, 8'h11, 0, 0, 0,  0, 0, 15'h4003, 0, 0, 1,  0, 8'h00};
    vecs[8]  = '{1, 14'd2, 0, 14'd0, 8'h00, 0, 0, 1,  1, 0, 15'h4002, 0, 0, 1,  0, 8'h00};
    vecs[9]  = '{0, 14'd0, 1, 14'd7, 8'h11, 0, 0, 0,  0, 1, 15'h4007, 1, 1, 1,  1, 8'h00};
    vecs[10] = '{1, 14'd1, 1, 14'd9, 8'h3C, 0, 0, 0,  1, 0, 15'h0001, 1, 0, 1,  0, 8'h00};
    vecs[11] = '{1, 14'd1, 1, 14'd9, 8'h3C, 0, 0, 0,  0, 1, 15'h4009, 1, 1, 1,  1, 8'h00};
    vecs[12] = '{1, 14'd1, 1, 14'd9, 8'h3C, 0, 0, 0,  1, 0, 15'h0001, 1, 0, 1,  0, 8'h00};
    vecs[13] = '{1, 14'd1, 1, 14'd9, 8'h3C, 0, 0, 0,  0, 1, 15'h4009, 1, 1, 1,  0, 8'h00};
    vecs[14] = '{0, 14'd0, 0, 14'd0, 8'h00, 0, 1, 0,  0, 0, 15'h4009, 1, 0, 1,  0, 8'h00};
    vecs[15] = '{0, 14'd0, 0, 14'd0, 8'h00, 1, 0, 0,  0, 0, 15'h4009, 1, 0, 1,  0, 8'h00};
    vecs[16] = '{0, 14'd0, 0, 14'd0, 8'h00, 0, 1, 1,  0, 0, 15'h4009, 0, 0, 1,  0, 8'h00};
    vecs[17] = '{1, 14'd0, 0, 14'd0, 8'h00, 0, 0, 0,  1, 0, 15'h4000, 1, 0, 1,  0, 8'h00};
    vecs[18] = '{0, 14'd0, 0, 14'd0, 8'h00, 1, 0, 0,  0, 0, 15'h4000, 1, 1, 1,  1, 8'h00};
    vecs[19] = '{0, 14'd0, 0, 14'd0, 8'h00, 0, 0, 0,  0, 0, 15'h4000, 0, 0, 1,  0, 8'h00};

    // Reset state, checked while reset is held
    resetn = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_gnt", rd_gnt, 0);
    chk("reset wr_gnt", wr_gnt, 0);
    chk("reset ram_we", ram_we, 0);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_frame_valid", rd_frame_valid, 0);
    chk("reset wr_ready", wr_ready, 1);
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      rd_req = vecs[i].rr; rd_addr = vecs[i].ra;
      wr_req = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      wr_frame_done = vecs[i].done;
      rd_session_start = vecs[i].st; rd_session_end = vecs[i].en;
      @(negedge clk);
      model_comb();
      chk($sformatf("v%0d rd_gnt", i), rd_gnt, vecs[i].e_rg);
      chk($sformatf("v%0d wr_gnt", i), wr_gnt, vecs[i].e_wg);
      chk($sformatf("v%0d ram_we", i), ram_we, vecs[i].e_wg);
      chk($sformatf("v%0d ram_addr", i), ram_addr, vecs[i].e_addr);
      chk($sformatf("v%0d wr_ready", i), wr_ready, vecs[i].e_wrdy);
      chk($sformatf("v%0d rd_valid", i), rd_valid, vecs[i].e_rv);
      chk($sformatf("v%0d rd_frame_valid", i), rd_frame_valid, vecs[i].e_fv);
      if (vecs[i].chk_d) chk($sformatf("v%0d rd_data", i), rd_data, vecs[i].e_d);
      if (vecs[i].wr) chk($sformatf("v%0d ram_wdata", i), ram_wdata, vecs[i].wd);
      $display("vec %0d: rr=%0b wr=%0b rd_gnt=%0b wr_gnt=%0b ram_addr=0x%04h wr_ready=%0b",
               i, rd_req, wr_req, rd_gnt, wr_gnt, ram_addr, wr_ready);
      model_edge();
      @(posedge clk); #1;
    end

    // Asynchronous reset while in SWAP_WAIT with a read in flight
    rd_req = 1; rd_addr = 14'd4;
    #2;
    resetn = 0;
    drive_idle();
    #1;
    chk("midreset rd_frame_valid", rd_frame_valid, 0);
    chk("midreset wr_ready", wr_ready, 1);
    chk("midreset rd_valid", rd_valid, 0);
    chk("midreset ram_addr", ram_addr, 0);
    chk("midreset ram_we", ram_we, 0);
    model_reset();
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;
    rd_req = 1; rd_addr = 14'd5;
    @(negedge clk);
    chk("postreset bank0 ram_addr", ram_addr, 15'h0005);
    model_comb();
    model_edge();
    @(posedge clk); #1;
    $display("reset sequence: done, first read ram_addr=0x%04h", ram_addr);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      rd_req = $urandom_range(0, 1);
      wr_req = $urandom_range(0, 1);
      rd_addr = 14'($urandom_range(0, 7));
      wr_addr = 14'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      wr_frame_done    = ($urandom_range(0, 9) == 0);
      rd_session_start = ($urandom_range(0, 7) == 0);
      rd_session_end   = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      model_comb();
      chk("rnd rd_gnt", rd_gnt, e_rg);
      chk("rnd wr_gnt", wr_gnt, e_wg);
      chk("rnd ram_we", ram_we, e_wg);
      chk("rnd ram_addr", ram_addr, e_addr);
      chk("rnd wr_ready", wr_ready, e_wrdy);
      chk("rnd rd_valid", rd_valid, m_rv);
      chk("rnd rd_frame_valid", rd_frame_valid, m_fv);
      if (m_rv) chk("rnd rd_data", rd_data, m_rdata);
      if (c % 100 == 0)
        $display("rnd %0d: rd_gnt=%0b wr_gnt=%0b ram_addr=0x%04h rd_valid=%0b", c, rd_gnt, wr_gnt, ram_addr, rd_valid);
      model_edge();
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
